// File: rtl/pe_stream_ctrl.sv
// Sequencing controller for one TAPS-tap signed PE: captures weights, resets the PE,
// streams samples under valid/ready and emits one result per convolution position.
// Build option: define PE_CTRL_RELU_EN to fuse a ReLU into output capture.
module pe_stream_ctrl #(
   parameter int N         = 8,
   parameter int SUM_WIDTH = 20,
   parameter int TAPS      = 7,
   parameter int PE_LAT    = 2,
   parameter int LEN_W     = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [LEN_W-1:0]     cfg_len,
   input  logic [N*TAPS-1:0]    cfg_win,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [N-1:0]         s_data,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [SUM_WIDTH-1:0] m_data,
   output logic                 pe_rst,
   output logic                 pe_ce,
   output logic [N-1:0]         pe_xin,
   output logic [N*TAPS-1:0]    pe_win,
   input  logic [SUM_WIDTH-1:0] pe_sum,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [2:0]           dbg_state
);

   // Valid/ready: a beat transfers on any rising edge where valid and ready are both 1;
   // a source holds data while valid is high and ready is low.

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_RUN   = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_WAIT  = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   localparam int DW = $clog2(PE_LAT) + 1;

   logic [2:0]           state_q, state_d;
   logic [LEN_W-1:0]     len_q, len_d;
   logic [LEN_W-1:0]     in_cnt_q, in_cnt_d;
   logic [DW-1:0]        drain_q, drain_d;
   logic [PE_LAT-1:0]    tag_q, tag_d;
   logic [N*TAPS-1:0]    win_q, win_d;
   logic                 m_valid_q, m_valid_d;
   logic [SUM_WIDTH-1:0] m_data_q, m_data_d;
   logic                 err_q, err_d;

   logic                 pend, cap, adv, ce, new_tag;
   logic [N-1:0]         xin;
   logic [SUM_WIDTH-1:0] cap_val;

   assign pend = tag_q[PE_LAT-1];
   assign cap  = pend & (~m_valid_q | m_ready);
   assign adv  = ~pend | cap;

`ifdef PE_CTRL_RELU_EN
   assign cap_val = pe_sum[SUM_WIDTH-1] ? '0 : pe_sum;
`else
   assign cap_val = pe_sum;
`endif

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      in_cnt_d  = in_cnt_q;
      drain_d   = drain_q;
      win_d     = win_q;
      err_d     = err_q;
      tag_d     = tag_q;
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      s_ready   = 1'b0;
      ce        = 1'b0;
      xin       = '0;
      new_tag   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               len_d   = cfg_len;
               win_d   = cfg_win;
               err_d   = 1'b0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            in_cnt_d = '0;
            drain_d  = '0;
            if (len_q < LEN_W'(TAPS)) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            s_ready = adv;
            ce      = s_valid & adv;
            xin     = s_data;
            // Only samples that complete a full window produce a result.
            new_tag = (in_cnt_q >= LEN_W'(TAPS - 1));
            if (ce) begin
               in_cnt_d = in_cnt_q + LEN_W'(1);
               if (in_cnt_q == len_q - LEN_W'(1)) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            ce = adv;
            if (ce) begin
               drain_d = drain_q + DW'(1);
               if (drain_q == DW'(PE_LAT - 1)) state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (~m_valid_q | m_ready) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // A shift into pend on the same edge overrides the clear from capture.
      if (ce) begin
         for (int i = PE_LAT - 1; i > 0; i--) tag_d[i] = tag_q[i-1];
         tag_d[0] = new_tag;
      end else if (cap) begin
         tag_d[PE_LAT-1] = 1'b0;
      end

      if (cap) begin
         m_valid_d = 1'b1;
         m_data_d  = cap_val;
      end else if (m_valid_q & m_ready) begin
         m_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         len_q     <= '0;
         in_cnt_q  <= '0;
         drain_q   <= '0;
         tag_q     <= '0;
         win_q     <= '0;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         in_cnt_q  <= in_cnt_d;
         drain_q   <= drain_d;
         tag_q     <= tag_d;
         win_q     <= win_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         err_q     <= err_d;
      end
   end

   assign pe_ce     = ce;
   assign pe_xin    = xin;
   assign pe_win    = win_q;
   assign pe_rst    = (state_q == S_LOAD);
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign err       = err_q;
   assign m_valid   = m_valid_q;
   assign m_data    = m_data_q;
   assign dbg_state = state_q;

endmodule

// File: doc/pe_stream_ctrl.md
# pe_stream_ctrl

Sequencing controller for one 7-tap signed PE in the ECG 1-D convolution datapath. It captures a weight set, resets the PE, and streams `cfg_len` samples through it under valid/ready flow control. It gates PE advance with a clock enable and emits one result per valid convolution position on an output stream. It sits between the sample buffer and the activation/pooling stage.

## Interface
- `N`, 8, sample and weight width (signed)
- `SUM_WIDTH`, 20, PE accumulator width, equal to 2*N+4
- `TAPS`, 7, kernel length; must match the PE
- `PE_LAT`, 2, number of PE `ce` edges from accepting sample x[k+TAPS-1] until `pe_sum` holds y[k]
- `LEN_W`, 10, width of the length and counter fields

- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: start request; accepted in IDLE only
- `cfg_len` in LEN_W: number of input samples; sampled when `start` is accepted
- `cfg_win` in N*TAPS: packed weights, {w6..w0}; sampled when `start` is accepted
- `s_valid` in 1, `s_ready` out 1, `s_data` in N: sample input stream
- `m_valid` out 1, `m_ready` in 1, `m_data` out SUM_WIDTH: result output stream
- `pe_rst` out 1: PE synchronous reset
- `pe_ce` out 1: PE clock enable; PE registers advance only when this is 1
- `pe_xin` out N: PE sample input
- `pe_win` out N*TAPS: PE weights (registered copy of `cfg_win`)
- `pe_sum` in SUM_WIDTH: PE result
- `busy` out 1: high in every state except IDLE
- `done` out 1: one-cycle pulse at job end
- `err` out 1: sticky flag, set when `cfg_len < TAPS`; cleared by the next accepted `start` or by `rst`

## Operation
- States and transitions:
  - IDLE: on `start`, capture `cfg_len` and `cfg_win`, then go to LOAD.
  - LOAD: one cycle; `pe_rst`=1. Go to RUN; go directly to DONE and set `err` if the captured length is below TAPS.
  - RUN: stream samples into the PE.
  - DRAIN: feed PE_LAT zero samples to flush the pipeline.
  - WAIT: hold until the output register is empty.
  - DONE: one cycle; `done`=1. Return to IDLE.
- Counters:
  - `in_cnt` counts accepted samples.
  - RUN exits to DRAIN when `in_cnt` reaches `len` on an accepting edge.
  - DRAIN counts PE_LAT `pe_ce` edges, then goes to WAIT.
- Tag pipeline: a PE_LAT-bit shift register advances on `pe_ce`.
  - The bit shifted in is 1 when the sample being accepted has index ≥ TAPS-1; it is 0 during DRAIN.
  - The last stage is `pend`.
- Output capture: `cap = pend & (!m_valid | m_ready)`.
  - On `cap`, `pe_sum` is loaded into `m_data` and `m_valid` is set.
  - `cap` clears `pend` unless the same edge shifts a new 1 into `pend`.
  - A handshake without `cap` clears `m_valid`.
- Advance condition: `adv = !pend | cap`.
  - RUN: `s_ready = adv`, `pe_ce = s_valid & adv`, `pe_xin = s_data`.
  - DRAIN: `pe_ce = adv`, `pe_xin = 0`.
  - All other states: `pe_ce` = 0.
- Result count: exactly `len-TAPS+1` results per job.
  - y[k] = Σ w_j·x[k+j], for j = 0..TAPS-1.
  - Products are full-precision signed; the sum is SUM_WIDTH signed with no saturation.
- `start` outside IDLE is ignored.
- `rst` in any state returns to IDLE within one edge. A partially transferred result is discarded.

## Timing
- Reset values:
  - `s_ready`, `m_valid`, `pe_ce`, `busy`, `done`, `err` = 0.
  - `pe_rst` = 0.
  - `m_data`, `pe_xin`, `pe_win` = 0.
  - Tag register, `pend`, and counters = 0.
- Start sequence: `start` accepted at edge t gives LOAD in cycle t+1 (`pe_rst`=1). RUN begins in cycle t+2, with `s_ready`=1 in that cycle.
- Streaming throughput: one sample per cycle when `s_valid` and `m_ready` are held high.
- Result latency: y[k] appears on `m_valid`/`m_data` one cycle after the PE_LAT-th `pe_ce` edge following acceptance of x[k+TAPS-1].
- Backpressure: `m_ready` low with `pend` set deasserts `s_ready` and `pe_ce` in that same cycle. No result is dropped or duplicated.
- `done` fires in the cycle after the last result handshake.
- `busy` stays high from LOAD through DONE inclusive.

## Configuration
- `PE_CTRL_RELU_EN`:
  - Defined: the captured value is `pe_sum < 0 ? 0 : pe_sum`. ReLU is fused into output capture.
  - Undefined: the raw signed `pe_sum` is passed through.
  - Timing is identical in both builds.

## Test plan
- Basic stream: weights all 1, samples x = 1..10, `cfg_len`=10, `m_ready`=1 -> exactly 4 results: 28, 35, 42, 49. Then one `done` pulse, then `busy`=0.
- Signed extremes: weights all -1, seven samples of 127 -> one result, -889 (without RELU) or 0 (with `PE_CTRL_RELU_EN`). Weights -128, samples -128, `cfg_len`=7 -> 114688.
- Backpressure and gaps: random `s_valid` and `m_ready` (50%) on the basic stream -> same 4 values in order. `s_ready` and `pe_ce` are 0 in every cycle where `pend & m_valid & !m_ready`.
- Short job: `cfg_len`=5 -> `err`=1, `pe_ce` never asserted, no `m_valid`, `done` in cycle t+2. The next `start` with `cfg_len`=7 clears `err`.
- Reset mid-job: assert `rst` after 6 accepted samples -> next cycle all outputs at reset values, state IDLE. A new job returns correct results.
- Ignored start: `start` pulsed during RUN -> no state change; result count unchanged.
